// File: rtl/median_pkg.sv
// Shared types for the median window and the downstream median network.
package median_pkg;

  typedef logic [31:0] data_t;

  localparam int unsigned N_TAPS = 10;

  typedef enum logic [0:0] {
    FILL   = 1'b0,
    STREAM = 1'b1
  } win_state_e;

endpackage

// File: rtl/median_win_ctrl.sv
// Window controller: fill/stream FSM, fill counter, stride counter and
// the win_valid handshake; decides when a sample is accepted.
module median_win_ctrl
  import median_pkg::*;
#(
  parameter int unsigned STRIDE = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush_i,
  input  logic       in_valid_i,
  input  logic       win_ready_i,
  output logic       in_ready_o,
  output logic       accept_o,
  output logic       win_valid_o,
  output logic [3:0] fill_count_o
);

  localparam logic [3:0] FULL_CNT   = 4'(N_TAPS);
  localparam logic [3:0] LAST_FILL  = 4'(N_TAPS - 1);
  localparam logic [3:0] STRIDE_CNT = 4'(STRIDE);

  win_state_e state_q, state_d;
  logic [3:0] fill_q, fill_d;
  logic [3:0] stride_q, stride_d;
  logic       win_valid_q, win_valid_d;

  // A held window blocks intake, so taps/fill stay frozen until consumed.
  assign in_ready_o   = !rst && !flush_i && (!win_valid_q || win_ready_i);
  assign accept_o     = in_valid_i && in_ready_o;
  assign win_valid_o  = win_valid_q;
  assign fill_count_o = fill_q;

  always_comb begin
    state_d     = state_q;
    fill_d      = fill_q;
    stride_d    = stride_q;
    win_valid_d = win_valid_q;

    if (win_valid_q && win_ready_i) begin
      win_valid_d = 1'b0;
    end

    // A completing accept overrides the consume-clear, so no bubble appears.
    if (accept_o) begin
      case (state_q)
        FILL: begin
          if (fill_q == LAST_FILL) begin
            fill_d      = FULL_CNT;
            state_d     = STREAM;
            stride_d    = '0;
            win_valid_d = 1'b1;
          end else begin
            fill_d = fill_q + 4'd1;
          end
        end
        STREAM: begin
          if (stride_q + 4'd1 == STRIDE_CNT) begin
            stride_d    = '0;
            win_valid_d = 1'b1;
          end else begin
            stride_d = stride_q + 4'd1;
          end
        end
        default: begin
          state_d = FILL;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      state_q     <= FILL;
      fill_q      <= '0;
      stride_q    <= '0;
      win_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      fill_q      <= fill_d;
      stride_q    <= stride_d;
      win_valid_q <= win_valid_d;
    end
  end

endmodule

// File: rtl/median_window_10.sv
// 10-tap sliding window feeding a median network; data_0 oldest, data_9 newest.
// Optional flush port enabled by defining MEDIAN_WIN_FLUSH_EN.
module median_window_10
  import median_pkg::*;
#(
  parameter int unsigned STRIDE = 1,
  parameter int unsigned WIDTH  = 32
) (
  input  logic             clk,
  input  logic             rst,
`ifdef MEDIAN_WIN_FLUSH_EN
  input  logic             flush,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             win_valid,
  input  logic             win_ready,
  output logic [WIDTH-1:0] data_0,
  output logic [WIDTH-1:0] data_1,
  output logic [WIDTH-1:0] data_2,
  output logic [WIDTH-1:0] data_3,
  output logic [WIDTH-1:0] data_4,
  output logic [WIDTH-1:0] data_5,
  output logic [WIDTH-1:0] data_6,
  output logic [WIDTH-1:0] data_7,
  output logic [WIDTH-1:0] data_8,
  output logic [WIDTH-1:0] data_9,
  output logic [3:0]       fill_count
);

  logic             flush_w;
  logic             accept;
  logic [WIDTH-1:0] tap_q [N_TAPS];

`ifdef MEDIAN_WIN_FLUSH_EN
  assign flush_w = flush;
`else
  assign flush_w = 1'b0;
`endif

  median_win_ctrl #(
    .STRIDE (STRIDE)
  ) u_ctrl (
    .clk          (clk),
    .rst          (rst),
    .flush_i      (flush_w),
    .in_valid_i   (in_valid),
    .win_ready_i  (win_ready),
    .in_ready_o   (in_ready),
    .accept_o     (accept),
    .win_valid_o  (win_valid),
    .fill_count_o (fill_count)
  );

  // Flush deliberately leaves the taps alone; only reset clears them.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < N_TAPS; i++) begin
        tap_q[i] <= '0;
      end
    end else if (accept) begin
      for (int unsigned i = 0; i < N_TAPS - 1; i++) begin
        tap_q[i] <= tap_q[i+1];
      end
      tap_q[N_TAPS-1] <= in_data;
    end
  end

  assign data_0 = tap_q[0];
  assign data_1 = tap_q[1];
  assign data_2 = tap_q[2];
  assign data_3 = tap_q[3];
  assign data_4 = tap_q[4];
  assign data_5 = tap_q[5];
  assign data_6 = tap_q[6];
  assign data_7 = tap_q[7];
  assign data_8 = tap_q[8];
  assign data_9 = tap_q[9];

endmodule

// File: tb/tb_median_window_10.sv
// Directed bench for median_window_10: one instance with STRIDE=1, one with STRIDE=3.
module tb_median_window_10;

  logic clk;
  int   n_vec  = 0;
  int   n_miss = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Instance A, STRIDE=1
  logic        a_rst, a_valid, a_ready, a_wvalid, a_wready;
  logic [31:0] a_data;
  logic [31:0] a_t [10];
  logic [3:0]  a_fill;
`ifdef MEDIAN_WIN_FLUSH_EN
  logic        a_flush = 1'b0;
`endif

  median_window_10 #(.STRIDE(1), .WIDTH(32)) u_dut (
    .clk        (clk),
    .rst        (a_rst),
`ifdef MEDIAN_WIN_FLUSH_EN
    .flush      (a_flush),
`endif
    .in_valid   (a_valid),
    .in_ready   (a_ready),
    .in_data    (a_data),
    .win_valid  (a_wvalid),
    .win_ready  (a_wready),
    .data_0     (a_t[0]),
    .data_1     (a_t[1]),
    .data_2     (a_t[2]),
    .data_3     (a_t[3]),
    .data_4     (a_t[4]),
    .data_5     (a_t[5]),
    .data_6     (a_t[6]),
    .data_7     (a_t[7]),
    .data_8     (a_t[8]),
    .data_9     (a_t[9]),
    .fill_count (a_fill)
  );

  // Instance B, STRIDE=3
  logic        b_rst, b_valid, b_ready, b_wvalid, b_wready;
  logic [31:0] b_data;
  logic [31:0] b_t [10];
  logic [3:0]  b_fill;
`ifdef MEDIAN_WIN_FLUSH_EN
  logic        b_flush = 1'b0;
`endif

  median_window_10 #(.STRIDE(3), .WIDTH(32)) u_dut3 (
    .clk        (clk),
    .rst        (b_rst),
`ifdef MEDIAN_WIN_FLUSH_EN
    .flush      (b_flush),
`endif
    .in_valid   (b_valid),
    .in_ready   (b_ready),
    .in_data    (b_data),
    .win_valid  (b_wvalid),
    .win_ready  (b_wready),
    .data_0     (b_t[0]),
    .data_1     (b_t[1]),
    .data_2     (b_t[2]),
    .data_3     (b_t[3]),
    .data_4     (b_t[4]),
    .data_5     (b_t[5]),
    .data_6     (b_t[6]),
    .data_7     (b_t[7]),
    .data_8     (b_t[8]),
    .data_9     (b_t[9]),
    .fill_count (b_fill)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drive A inputs, let in_ready settle, clock once, then sample #1 after the edge.
  task automatic cyc_a(input logic v, input logic [31:0] d, input logic wr);
    a_valid  = v;
    a_data   = d;
    a_wready = wr;
    @(posedge clk);
    #1;
  endtask

  task automatic reset_a();
    a_rst = 1'b1; a_valid = 1'b0; a_data = '0; a_wready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    a_rst = 1'b0;
  endtask

  // Check a full window of consecutive samples first..first+9 on instance A.
  task automatic check_win_a(input string tag, input logic [31:0] first);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("%s_tap%0d", tag, i), a_t[i], first + 32'(i));
    end
  endtask

  int win_cnt;

  initial begin
    a_rst = 1'b1; a_valid = 1'b0; a_data = '0; a_wready = 1'b1;
    b_rst = 1'b1; b_valid = 1'b0; b_data = '0; b_wready = 1'b1;

    // Reset state, plus a sample offered during reset must be refused
    a_valid = 1'b1; a_data = 32'd77;
    @(posedge clk); #1;
    check("rst_in_ready", {31'd0, a_ready}, 32'd0);
    @(posedge clk); #1;
    check("rst_win_valid", {31'd0, a_wvalid}, 32'd0);
    check("rst_fill", {28'd0, a_fill}, 32'd0);
    check("rst_data9", a_t[9], 32'd0);
    a_rst = 1'b0; a_valid = 1'b0;
    #1;
    check("post_rst_in_ready", {31'd0, a_ready}, 32'd1);

    // Fill 1..10, window appears exactly one cycle after sample 10
    for (int s = 1; s <= 10; s++) begin
      cyc_a(1'b1, 32'(s), 1'b1);
      check($sformatf("fill_wv_s%0d", s), {31'd0, a_wvalid}, (s == 10) ? 32'd1 : 32'd0);
      check($sformatf("fill_cnt_s%0d", s), {28'd0, a_fill}, 32'(s));
    end
    check_win_a("w1", 32'd1);

    // STRIDE=1: back-to-back windows, no bubble
    cyc_a(1'b1, 32'd11, 1'b1);
    check("b2b_wv1", {31'd0, a_wvalid}, 32'd1);
    check_win_a("w2", 32'd2);
    cyc_a(1'b1, 32'd12, 1'b1);
    check("b2b_wv2", {31'd0, a_wvalid}, 32'd1);
    check("b2b_fill", {28'd0, a_fill}, 32'd10);
    check_win_a("w3", 32'd3);
    cyc_a(1'b0, 32'd0, 1'b1);
    check("consume_clear", {31'd0, a_wvalid}, 32'd0);

    // Backpressure: window 1..10 held for 5 cycles while a sample is offered
    reset_a();
    for (int s = 1; s <= 10; s++) cyc_a(1'b1, 32'(s), 1'b0);
    for (int c = 0; c < 5; c++) begin
      a_valid = 1'b1; a_data = 32'd99; a_wready = 1'b0;
      #1;
      check($sformatf("bp_in_ready_c%0d", c), {31'd0, a_ready}, 32'd0);
      @(posedge clk); #1;
      check($sformatf("bp_wv_c%0d", c), {31'd0, a_wvalid}, 32'd1);
      check($sformatf("bp_d0_c%0d", c), a_t[0], 32'd1);
      check($sformatf("bp_d9_c%0d", c), a_t[9], 32'd10);
      check($sformatf("bp_fill_c%0d", c), {28'd0, a_fill}, 32'd10);
    end
    a_valid = 1'b0; a_wready = 1'b1;
    #1;
    check_win_a("bp_deliver", 32'd1);
    @(posedge clk); #1;
    check("bp_consumed", {31'd0, a_wvalid}, 32'd0);
    check("bp_d9_after", a_t[9], 32'd10);

    // Reset mid-window discards partial contents
    reset_a();
    for (int s = 1; s <= 6; s++) cyc_a(1'b1, 32'(s), 1'b1);
    a_rst = 1'b1;
    cyc_a(1'b1, 32'd55, 1'b1);
    a_rst = 1'b0;
    check("midrst_fill", {28'd0, a_fill}, 32'd0);
    for (int s = 20; s <= 29; s++) begin
      cyc_a(1'b1, 32'(s), 1'b1);
      check($sformatf("midrst_wv_s%0d", s), {31'd0, a_wvalid}, (s == 29) ? 32'd1 : 32'd0);
    end
    check_win_a("midrst_win", 32'd20);

`ifdef MEDIAN_WIN_FLUSH_EN
    // Flush wins over a simultaneous sample; taps retained
    reset_a();
    for (int s = 1; s <= 6; s++) cyc_a(1'b1, 32'(s), 1'b1);
    a_flush = 1'b1; a_valid = 1'b1; a_data = 32'd7;
    #1;
    check("flush_in_ready", {31'd0, a_ready}, 32'd0);
    @(posedge clk); #1;
    a_flush = 1'b0; a_valid = 1'b0;
    check("flush_fill", {28'd0, a_fill}, 32'd0);
    check("flush_wv", {31'd0, a_wvalid}, 32'd0);
    check("flush_d9_kept", a_t[9], 32'd6);
`endif

    // STRIDE=3: samples 1..16 give windows ending at 10, 13, 16
    @(posedge clk); #1;
    b_rst = 1'b0;
    win_cnt = 0;
    for (int s = 1; s <= 16; s++) begin
      b_valid = 1'b1; b_data = 32'(s); b_wready = 1'b1;
      @(posedge clk); #1;
      check($sformatf("s3_wv_s%0d", s), {31'd0, b_wvalid},
            (s == 10 || s == 13 || s == 16) ? 32'd1 : 32'd0);
      if (b_wvalid) begin
        win_cnt++;
        check($sformatf("s3_d0_s%0d", s), b_t[0], 32'(s - 9));
        check($sformatf("s3_d9_s%0d", s), b_t[9], 32'(s));
      end
    end
    b_valid = 1'b0;
    check("s3_win_count", 32'(win_cnt), 32'd3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
